// File: rtl/pll_cal_pkg.sv
// Shared constants for the PLL coarse-band calibration sequencer: FSM state codes and default parameters.
package pll_cal_pkg;

    localparam int BAND_W_DEF        = 4;
    localparam int CNT_W_DEF         = 8;
    localparam int SETTLE_CYCLES_DEF = 16;
    localparam int WIN_CYCLES_DEF    = 64;
    localparam int TOL_DEF           = 1;
    localparam int LOCK_WINDOWS_DEF  = 4;

    typedef logic [2:0] cal_state_t;

    localparam cal_state_t IDLE    = 3'd0;
    localparam cal_state_t SETTLE  = 3'd1;
    localparam cal_state_t COUNT   = 3'd2;
    localparam cal_state_t DECIDE  = 3'd3;
    localparam cal_state_t RELEASE = 3'd4;
    localparam cal_state_t TRACK   = 3'd5;

endpackage

// File: rtl/pll_win_counter.sv
// Windowed saturating event counter: counts tick_i over WIN_CYCLES enabled cycles, then starts a fresh window.
module pll_win_counter #(
    parameter int CNT_W      = 8,
    parameter int WIN_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] count_o,
    output logic             win_done_o
);

    localparam int                CYC_W    = $clog2(WIN_CYCLES + 1);
    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] base;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic t);
        logic [CNT_W-1:0] r;
        if (t && (a == CNT_MAX)) r = CNT_MAX;
        else                     r = a + CNT_W'(t);
        return r;
    endfunction

    // count_q keeps the finished window's total until the next window's first tick overwrites it
    assign base       = (cyc_q == '0) ? '0 : count_q;
    assign count_o    = sat_inc(base, tick_i);
    assign win_done_o = en_i && (cyc_q == CYC_LAST);

    always_comb begin
        cyc_d   = cyc_q;
        count_d = count_q;
        if (clr_i) begin
            cyc_d   = '0;
            count_d = '0;
        end else if (en_i) begin
            count_d = count_o;
            cyc_d   = win_done_o ? '0 : cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q   <= '0;
            count_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pll_band_cal_ctrl.sv
// SAR coarse-band calibration sequencer for the charge-pump PLL (reference-clock domain).
// Optional post-calibration frequency-lock monitor enabled by defining LOCK_MON_EN.
import pll_cal_pkg::*;

module pll_band_cal_ctrl #(
    parameter int BAND_W        = BAND_W_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int WIN_CYCLES    = WIN_CYCLES_DEF,
    parameter int TOL           = TOL_DEF,
    parameter int LOCK_WINDOWS  = LOCK_WINDOWS_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Fb_tick,
    input  logic [CNT_W-1:0]  Target,
    output logic [BAND_W-1:0] Band,
    output logic              Pfd_Resetn,
    output logic              Vctrl_hold,
    output logic              Busy,
    output logic              Done,
    output logic              Locked
);

    localparam int                 IDX_W       = (BAND_W > 1) ? $clog2(BAND_W) : 1;
    localparam int                 ST_W        = $clog2(SETTLE_CYCLES + 1);
    localparam logic [BAND_W-1:0]  BAND_INIT   = BAND_W'(1) << (BAND_W - 1);
    localparam logic [IDX_W-1:0]   IDX_INIT    = IDX_W'(BAND_W - 1);
    localparam logic [ST_W-1:0]    SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);

    if ((WIN_CYCLES < 1) || (WIN_CYCLES > (2 ** CNT_W) - 1) || (SETTLE_CYCLES < 1) ||
        (TOL < 0) || (LOCK_WINDOWS < 1)) begin : g_param_check
        $error("pll_band_cal_ctrl: illegal parameter set");
    end

    cal_state_t        state_q, state_d;
    logic [BAND_W-1:0] band_q, band_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  idx_dec;
    logic [ST_W-1:0]   settle_q, settle_d;
    logic              over_q, over_d;
    logic              pfd_q, pfd_d;
    logic              vhold_q, vhold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              locked_q, locked_d;
    logic              start_cal;
    logic              cnt_clr, cnt_en, win_done;
    logic [CNT_W-1:0]  count;

`ifdef LOCK_MON_EN
    localparam int                GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam logic [GOOD_W-1:0] GOOD_N = GOOD_W'(LOCK_WINDOWS);

    logic [GOOD_W-1:0] good_q, good_d;

    // Distance is taken one bit wider than the counter so it can never wrap
    function automatic logic within_tol(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] ea, eb, diff;
        ea   = {1'b0, a};
        eb   = {1'b0, b};
        diff = (ea >= eb) ? (ea - eb) : (eb - ea);
        return diff <= (CNT_W + 1)'(TOL);
    endfunction
`endif

    pll_win_counter #(
        .CNT_W      (CNT_W),
        .WIN_CYCLES (WIN_CYCLES)
    ) u_win (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .tick_i     (Fb_tick),
        .count_o    (count),
        .win_done_o (win_done)
    );

    assign idx_dec   = idx_q - 1'b1;
    assign start_cal = Start && ((state_q == IDLE) || (state_q == TRACK));

    always_comb begin
        state_d  = state_q;
        band_d   = band_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        over_d   = over_q;
        pfd_d    = pfd_q;
        vhold_d  = vhold_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        locked_d = locked_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
`ifdef LOCK_MON_EN
        good_d   = good_q;
`endif
        case (state_q)
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    cnt_clr  = 1'b1;
                    state_d  = COUNT;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            COUNT: begin
                cnt_en = 1'b1;
                if (win_done) begin
                    over_d  = (count > Target);
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                if (over_q) band_d[idx_q] = 1'b0;
                if (idx_q != '0) begin
                    band_d[idx_dec] = 1'b1;
                    idx_d           = idx_dec;
                    state_d         = SETTLE;
                end else begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                pfd_d   = 1'b1;
                vhold_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_clr = 1'b1;
`ifdef LOCK_MON_EN
                state_d = TRACK;
`else
                locked_d = 1'b1;
                state_d  = IDLE;
`endif
            end
`ifdef LOCK_MON_EN
            TRACK: begin
                cnt_en = 1'b1;
                if (win_done) begin
                    if (within_tol(count, Target)) begin
                        if (good_q < GOOD_N)         good_d   = good_q + 1'b1;
                        if (good_q >= GOOD_N - 1'b1) locked_d = 1'b1;
                    end else begin
                        good_d   = '0;
                        locked_d = 1'b0;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A new calibration overrides whatever IDLE or TRACK was doing
        if (start_cal) begin
            state_d  = SETTLE;
            band_d   = BAND_INIT;
            idx_d    = IDX_INIT;
            settle_d = '0;
            pfd_d    = 1'b0;
            vhold_d  = 1'b1;
            busy_d   = 1'b1;
            locked_d = 1'b0;
`ifdef LOCK_MON_EN
            good_d   = '0;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            band_q   <= BAND_INIT;
            idx_q    <= IDX_INIT;
            settle_q <= '0;
            over_q   <= 1'b0;
            pfd_q    <= 1'b0;
            vhold_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
`ifdef LOCK_MON_EN
            good_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            band_q   <= band_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            over_q   <= over_d;
            pfd_q    <= pfd_d;
            vhold_q  <= vhold_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            locked_q <= locked_d;
`ifdef LOCK_MON_EN
            good_q   <= good_d;
`endif
        end
    end

    assign Band       = band_q;
    assign Pfd_Resetn = pfd_q;
    assign Vctrl_hold = vhold_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Locked     = locked_q;

endmodule

// File: tb/tb_pll_band_cal_ctrl.sv
// Directed bench for pll_band_cal_ctrl; lock-monitor scenario compiled in when LOCK_MON_EN is defined.
import pll_cal_pkg::*;

module tb_pll_band_cal_ctrl;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       Fb_tick;
    logic [7:0] Target;
    logic [3:0] Band;
    logic       Pfd_Resetn, Vctrl_hold, Busy, Done, Locked;

    logic       Start6;
    logic       Fb_tick6;
    logic [5:0] Target6;
    logic [3:0] Band6;
    logic       Pfd_Resetn6, Vctrl_hold6, Busy6, Done6, Locked6;

    int checks;
    int errors;
    int phase;
    bit manual_mode;
    logic man_tick;

    pll_band_cal_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Fb_tick    (Fb_tick),
        .Target     (Target),
        .Band       (Band),
        .Pfd_Resetn (Pfd_Resetn),
        .Vctrl_hold (Vctrl_hold),
        .Busy       (Busy),
        .Done       (Done),
        .Locked     (Locked)
    );

    pll_band_cal_ctrl #(.CNT_W(6), .WIN_CYCLES(63)) dut6 (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start6),
        .Fb_tick    (Fb_tick6),
        .Target     (Target6),
        .Band       (Band6),
        .Pfd_Resetn (Pfd_Resetn6),
        .Vctrl_hold (Vctrl_hold6),
        .Busy       (Busy6),
        .Done       (Done6),
        .Locked     (Locked6)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // VCO model: 4*Band ticks in every 64 consecutive cycles (fits one tick per clock)
    task automatic step();
        if (manual_mode) Fb_tick = man_tick;
        else             Fb_tick = (phase < 4 * int'(Band));
        phase = (phase + 1) % 64;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic run_cal(input logic [7:0] tgt, input bit poke, output int lat, output int busy_low);
        Target = tgt;
        Start  = 1'b1;
        step();
        Start    = 1'b0;
        lat      = 0;
        busy_low = 0;
        while (Done !== 1'b1 && lat < 400) begin
            if (Busy !== 1'b1) busy_low++;
            Start = poke && (lat % 37 == 5);
            step();
            lat++;
        end
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        checks++; if (Band !== 4'b1000) begin errors++; $display("FAIL rst_band got %b want 1000", Band); end
        checks++; if (Pfd_Resetn !== 1'b0) begin errors++; $display("FAIL rst_pfd got %b want 0", Pfd_Resetn); end
        checks++; if (Vctrl_hold !== 1'b1) begin errors++; $display("FAIL rst_vhold got %b want 1", Vctrl_hold); end
        checks++; if ({Busy, Done, Locked} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {Busy, Done, Locked}); end
        Reset = 1'b0;
        step();
        step();
        checks++; if (Busy !== 1'b0 || dut.state_q !== IDLE) begin errors++; $display("FAIL idle_hold busy %b state %0d want 0/%0d", Busy, dut.state_q, IDLE); end

        // Start, then reset during the second trial's counting window
        Target = 8'd30;
        Start  = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 100; i++) step();
        checks++; if (dut.state_q !== COUNT) begin errors++; $display("FAIL midcount_state got %0d want %0d", dut.state_q, COUNT); end
        checks++; if (Band !== 4'b0100) begin errors++; $display("FAIL midcount_band got %b want 0100", Band); end
        Reset = 1'b1;
        step();
        checks++; if (Band !== 4'b1000) begin errors++; $display("FAIL rst2_band got %b want 1000", Band); end
        checks++; if ({Pfd_Resetn, Vctrl_hold} !== 2'b01) begin errors++; $display("FAIL rst2_loop got %b want 01", {Pfd_Resetn, Vctrl_hold}); end
        checks++; if ({Busy, Done, Locked} !== 3'b000) begin errors++; $display("FAIL rst2_flags got %b want 000", {Busy, Done, Locked}); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst2_state got %0d want %0d", dut.state_q, IDLE); end
        checks++; if (dut.u_win.count_q !== 8'd0) begin errors++; $display("FAIL rst2_count got %0d want 0", dut.u_win.count_q); end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_sar();
        int lat, busy_low;
        // trials 8 (32>30 clear), 4 (16), 6 (24), 7 (28) -> 7
        run_cal(8'd30, 1'b0, lat, busy_low);
        checks++; if (lat != 325) begin errors++; $display("FAIL sar_latency got %0d want 325", lat); end
        checks++; if (busy_low != 0) begin errors++; $display("FAIL sar_busy low cycles got %0d want 0", busy_low); end
        checks++; if (Band !== 4'd7) begin errors++; $display("FAIL sar_band got %0d want 7", Band); end
        checks++; if ({Pfd_Resetn, Vctrl_hold, Busy} !== 3'b100) begin errors++; $display("FAIL sar_release got %b want 100", {Pfd_Resetn, Vctrl_hold, Busy}); end
`ifndef LOCK_MON_EN
        checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL nolock_locked got %b want 1", Locked); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL nolock_state got %0d want %0d", dut.state_q, IDLE); end
`endif
        step();
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", Done); end
        checks++; if ({Pfd_Resetn, Vctrl_hold} !== 2'b10) begin errors++; $display("FAIL loop_closed got %b want 10", {Pfd_Resetn, Vctrl_hold}); end
`ifndef LOCK_MON_EN
        for (int i = 0; i < 10; i++) step();
        checks++; if (Locked !== 1'b1 || Band !== 4'd7) begin errors++; $display("FAIL nolock_hold locked %b band %0d want 1/7", Locked, Band); end
        Start = 1'b1;
        step();
        Start = 1'b0;
        checks++; if ({Locked, Busy} !== 2'b01 || Band !== 4'b1000) begin errors++; $display("FAIL restart locked/busy %b band %b want 01/1000", {Locked, Busy}, Band); end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
`endif
    endtask

    task automatic test_boundaries();
        int lat, busy_low;
        run_cal(8'd0, 1'b0, lat, busy_low);
        checks++; if (Band !== 4'd0) begin errors++; $display("FAIL tgt0_band got %0d want 0", Band); end
        run_cal(8'd255, 1'b0, lat, busy_low);
        checks++; if (Band !== 4'd15) begin errors++; $display("FAIL tgt255_band got %0d want 15", Band); end
        // trial 7 gives exactly 28: equality keeps the bit; Start pulses while busy are ignored
        run_cal(8'd28, 1'b1, lat, busy_low);
        checks++; if (Band !== 4'd7) begin errors++; $display("FAIL equal_band got %0d want 7", Band); end
        checks++; if (lat != 325) begin errors++; $display("FAIL poke_latency got %0d want 325", lat); end
        run_cal(8'd27, 1'b0, lat, busy_low);
        checks++; if (Band !== 4'd6) begin errors++; $display("FAIL above_band got %0d want 6", Band); end
    endtask

`ifdef LOCK_MON_EN
    task automatic test_lock();
        int lat, busy_low;
        int win_n [5];
        logic want [5];
        win_n = '{29, 31, 30, 29, 35};
        want  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        run_cal(8'd30, 1'b0, lat, busy_low);
        checks++; if (Band !== 4'd7 || Locked !== 1'b0) begin errors++; $display("FAIL lock_cal band %0d locked %b want 7/0", Band, Locked); end
        manual_mode = 1'b1;
        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < 64; i++) begin
                man_tick = (i < win_n[w]);
                step();
                if (i == 62 && (w == 3 || w == 4)) begin
                    checks++;
                    if (Locked !== want[w - 1]) begin errors++; $display("FAIL lock_early w%0d got %b want %b", w, Locked, want[w - 1]); end
                end
            end
            checks++;
            if (Locked !== want[w]) begin errors++; $display("FAIL lock_win w%0d got %b want %b", w, Locked, want[w]); end
        end
        manual_mode = 1'b0;
    endtask
`endif

    task automatic test_saturate();
        int n;
        Target6 = 6'd50;
        Start6  = 1'b1;
        step();
        Start6 = 1'b0;
        n = 0;
        while (dut6.state_q !== DECIDE && n < 200) begin step(); n++; end
        checks++; if (dut6.state_q !== DECIDE) begin errors++; $display("FAIL sat_reach state %0d want %0d", dut6.state_q, DECIDE); end
        checks++; if (dut6.u_win.count_q !== 6'd63) begin errors++; $display("FAIL sat_count got %0d want 63", dut6.u_win.count_q); end
        step();
        checks++; if (Band6 !== 4'b0100) begin errors++; $display("FAIL sat_band1 got %b want 0100", Band6); end
        n = 0;
        while (Done6 !== 1'b1 && n < 400) begin step(); n++; end
        checks++; if (Done6 !== 1'b1 || Band6 !== 4'd0) begin errors++; $display("FAIL sat_final done %b band %0d want 1/0", Done6, Band6); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        phase       = 0;
        manual_mode = 1'b0;
        man_tick    = 1'b0;
        Reset       = 1'b1;
        Start       = 1'b0;
        Fb_tick     = 1'b0;
        Target      = 8'd0;
        Start6      = 1'b0;
        Fb_tick6    = 1'b1;
        Target6     = 6'd0;
        @(negedge Clk);
        test_reset();
        test_sar();
        test_boundaries();
`ifdef LOCK_MON_EN
        test_lock();
`endif
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
